// File: rtl/xnor_serial_adder.sv
// Bit-serial XNOR approximate adder: one cell evaluation per clock, LSB first,
// with operand and result handshakes on valid/ready.
module xnor_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] input1_i,
  input  logic [WIDTH-1:0] input2_i,
  input  logic             carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             ready_q;
  logic             bit_x, bit_s, bit_c;
  logic             accept, release_res, last_bit;

  assign bit_x = a_sh[0] ^ b_sh[0];
  assign bit_s = ~bit_x & carry_q;
  assign bit_c = (bit_x & carry_q) | (a_sh[0] & b_sh[0]);

  // ready_q keeps in_ready_o low until the first clock edge after reset release
  assign in_ready_o  = (state == IDLE) & ready_q;
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign sum_o       = sum_q;
  assign carry_o     = carry_q;

  assign accept      = in_valid_i & in_ready_o;
  assign release_res = out_valid_o & out_ready_i;
  assign last_bit    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (release_res) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sh    <= input1_i;
      b_sh    <= input2_i;
      carry_q <= carry_i;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      sum_q   <= {bit_s, sum_q[WIDTH-1:1]};
      carry_q <= bit_c;
      if (!last_bit) cnt <= cnt + 1'b1;
    end
  end

endmodule
